unidade_busca: RTL and testbench

Instruction-fetch and PC-sequencing unit for the single-cycle processor. It owns the program counter and drives the synchronous instruction memory. It presents `Opcode`/`Funct`/immediate fields to the control unit (`UnidadeControle`), then consumes that unit's `PCWrite`, `Cond`, `Jump` and `JumpValue` outputs to choose the next PC. It is the consumer end of the control-unit interface and sits between instruction memory and the decode/execute datapath.

---
 rtl/processador_pkg.sv | 38 +++
 rtl/calc_proximo_pc.sv | 43 ++++
 rtl/unidade_busca.sv | 108 ++++++++++
 tb/tb_unidade_busca.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processador_pkg.sv
// Shared definitions for the fetch unit and its control-unit interface:
// instruction field positions, JumpValue target-select encodings, the HALT
// encoding and the fetch FSM state type.
package processador_pkg;

  // Instruction field layout: [15:14] opcode, [13:11] funct, [10:0] imm
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 14;
  localparam int FUNCT_MSB  = 13;
  localparam int FUNCT_LSB  = 11;
  localparam int IMM_MSB    = 10;
  localparam int IMM_LSB    = 0;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int FUNCT_W    = FUNCT_MSB - FUNCT_LSB + 1;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

  // Relative branches use only the low byte of the immediate, sign-extended
  localparam int REL_W = 8;

  // Target select driven by the control unit
  typedef enum logic [1:0] {
    JV_SEQ = 2'b00,
    JV_REL = 2'b01,
    JV_ABS = 2'b10,
    JV_REG = 2'b11
  } jump_value_t;

  // HALT is opcode 3 / funct 7 presented while the control unit holds PCWrite low
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 2'b11;
  localparam logic [FUNCT_W-1:0]  HALT_FUNCT  = 3'b111;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } estado_t;

endpackage

// File: rtl/calc_proximo_pc.sv
// Next-PC selector: sequential, PC-relative, absolute or register target.
// Purely combinational (zero latency), no backpressure; sits on the critical
// path imem_data -> control unit -> JumpValue/Zero -> imem_addr.
// Ports: pc, Imm, RegJumpAddr, Jump, Cond, Zero, JumpValue in; target out.
module calc_proximo_pc
  import processador_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  Imm,
  input  logic [ADDR_W-1:0] RegJumpAddr,
  input  logic              Jump,
  input  logic              Cond,
  input  logic              Zero,
  input  logic [1:0]        JumpValue,
  output logic [ADDR_W-1:0] target
);

  logic              taken;
  logic [ADDR_W-1:0] rel_off;

  assign taken   = Jump | (Cond & Zero);
  // Sign-extend the low immediate byte; the adder then wraps naturally mod 2^ADDR_W
  assign rel_off = ADDR_W'($signed(Imm[REL_W-1:0]));

  always_comb begin
    target = pc + ADDR_W'(1);
    if (taken) begin
      case (jump_value_t'(JumpValue))
        JV_REL:  target = pc + rel_off;
        JV_ABS:  target = Imm[ADDR_W-1:0];
        JV_REG:  target = RegJumpAddr;
        default: target = pc + ADDR_W'(1);
      endcase
    end
  end

  // Upper immediate bits only matter for wider address configurations
  logic unused_imm;
  assign unused_imm = ^Imm;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch / PC sequencing: owns pc, drives the synchronous ROM
// address, splits the fetched word into Opcode/Funct/Imm for the control unit.
// Latency: one BOOT bubble after reset, then one instruction per cycle with no
// taken-branch bubble. PCWrite=0 stalls (same word re-presented) or, on the
// HALT encoding, parks the unit until reset.
// Ports: clk, reset_n; imem_addr/imem_data to ROM; Opcode/Funct/Imm,
// instr_valid, pc_out, pc_plus1, halted out; PCWrite, Cond, Jump, JumpValue,
// Zero, RegJumpAddr from control unit / datapath.
module unidade_busca
  import processador_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [OPCODE_W-1:0] Opcode,
  output logic [FUNCT_W-1:0]  Funct,
  output logic [IMM_W-1:0]    Imm,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [ADDR_W-1:0]   pc_plus1,
  output logic                halted,
  input  logic                PCWrite,
  input  logic                Cond,
  input  logic                Jump,
  input  logic [1:0]          JumpValue,
  input  logic                Zero,
  input  logic [ADDR_W-1:0]   RegJumpAddr
);

  estado_t           state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] target;
  logic              run;
  logic              halt_word;

  assign run = (state == RUN);

  // Fields come straight from the ROM output; outside RUN they collapse to NOP
  assign Opcode = run ? imem_data[OPCODE_MSB:OPCODE_LSB] : '0;
  assign Funct  = run ? imem_data[FUNCT_MSB:FUNCT_LSB]   : '0;
  assign Imm    = run ? imem_data[IMM_MSB:IMM_LSB]       : '0;

  assign halt_word = (imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) &&
                     (imem_data[FUNCT_MSB:FUNCT_LSB]   == HALT_FUNCT);

  assign pc_out   = pc;
  assign pc_plus1 = pc + ADDR_W'(1);

  calc_proximo_pc #(
    .ADDR_W(ADDR_W)
  ) u_calc_proximo_pc (
    .pc          (pc),
    .Imm         (Imm),
    .RegJumpAddr (RegJumpAddr),
    .Jump        (Jump),
    .Cond        (Cond),
    .Zero        (Zero),
    .JumpValue   (JumpValue),
    .target      (target)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // imem_addr always equals the value pc will hold after the edge, so the ROM
  // word arriving next cycle is the one addressed by pc.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    imem_addr   = pc;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      BOOT: begin
        imem_addr  = RESET_PC;
        state_next = RUN;
      end
      RUN: begin
        instr_valid = 1'b1;
        if (PCWrite) begin
          imem_addr = target;
          pc_next   = target;
        end else if (halt_word) begin
          state_next = HALT;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: synchronous ROM model, table-driven next-PC vectors,
// hand sequences for stall / HALT / async reset, and a randomized run against
// an arithmetic reference model.
module tb_unidade_busca;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [1:0]  Opcode;
  logic [2:0]  Funct;
  logic [10:0] Imm;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic [7:0]  pc_plus1;
  logic        halted;
  logic        PCWrite, Cond, Jump, Zero;
  logic [1:0]  JumpValue;
  logic [7:0]  RegJumpAddr;

  logic [15:0] rom [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency
  always @(posedge clk) imem_data <= rom[imem_addr];

  unidade_busca #(
    .ADDR_W   (8),
    .INSTR_W  (16),
    .RESET_PC (8'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .Opcode      (Opcode),
    .Funct       (Funct),
    .Imm         (Imm),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pc_plus1    (pc_plus1),
    .halted      (halted),
    .PCWrite     (PCWrite),
    .Cond        (Cond),
    .Jump        (Jump),
    .JumpValue   (JumpValue),
    .Zero        (Zero),
    .RegJumpAddr (RegJumpAddr)
  );

  typedef struct {
    int          start_pc;
    logic [1:0]  op;
    logic [2:0]  fn;
    logic [10:0] imm;
    logic        jump;
    logic        cond;
    logic        zero;
    logic [1:0]  jv;
    logic [7:0]  reg_addr;
    int          exp_next;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic set_ctl(input logic pw, input logic j, input logic c, input logic z,
                         input logic [1:0] jv, input logic [7:0] ra);
    PCWrite     = pw;
    Jump        = j;
    Cond        = c;
    Zero        = z;
    JumpValue   = jv;
    RegJumpAddr = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-indirect jump to an arbitrary address; requires RUN
  task automatic goto(input logic [7:0] a);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, a);
    #1;
    tick();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"},  int'(instr_valid), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_opcode"}, int'(Opcode), 0);
    chk({tag, "_funct"},  int'(Funct), 0);
    chk({tag, "_imm"},    int'(Imm), 0);
    chk({tag, "_addr"},   int'(imem_addr), 0);
    chk({tag, "_pc"},     int'(pc_out), 0);
    chk({tag, "_pc1"},    int'(pc_plus1), 1);
  endtask

  // Holds reset low across one rising edge, releases on the falling edge.
  // On return the DUT is in its BOOT cycle.
  task automatic pulse_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_values(tag);
    @(posedge clk);
    #1;
    chk({tag, "_held_pc"}, int'(pc_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference next-PC from the rules, plain integer arithmetic
  function automatic int ref_next(input int pc, input logic [10:0] imm, input logic j,
                                  input logic c, input logic z, input logic [1:0] jv,
                                  input logic [7:0] ra);
    int t;
    int off;
    t = pc + 1;
    if (j || (c && z)) begin
      off = int'(imm[7:0]);
      if (off >= 128) off = off - 256;
      if (jv == 2'b01)      t = pc + off;
      else if (jv == 2'b10) t = int'(imm) % 256;
      else if (jv == 2'b11) t = int'(ra);
    end
    return ((t % 256) + 256) % 256;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    bit  m_boot, m_halt;
    int  m_pc, halt_cycles, tgt, e_addr;
    logic pw, j, c, z;
    logic [1:0] jv;
    logic [7:0] ra;

    vecs[0]  = '{10,   2'd0, 3'd1, 11'h0FC, 1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 11};
    vecs[1]  = '{10,   2'd0, 3'd1, 11'h0FC, 1'b0, 1'b1, 1'b1, 2'b01, 8'h00, 6};
    vecs[2]  = '{10,   2'd2, 3'd0, 11'h040, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 'h40};
    vecs[3]  = '{10,   2'd2, 3'd3, 11'h000, 1'b1, 1'b0, 1'b0, 2'b11, 8'h99, 'h99};
    vecs[4]  = '{30,   2'd1, 3'd0, 11'h0FC, 1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 31};
    vecs[5]  = '{30,   2'd1, 3'd0, 11'h040, 1'b1, 1'b0, 1'b0, 2'b00, 8'h77, 31};
    vecs[6]  = '{255,  2'd0, 3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 0};
    vecs[7]  = '{2,    2'd1, 3'd5, 11'h080, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 'h82};
    vecs[8]  = '{'hF0, 2'd2, 3'd6, 11'h07F, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 'h6F};
    vecs[9]  = '{10,   2'd0, 3'd4, 11'h7AB, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 'hAB};
    vecs[10] = '{50,   2'd1, 3'd1, 11'h005, 1'b0, 1'b1, 1'b1, 2'b11, 8'h33, 'h33};

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);

    // Async reset from an unknown state, then BOOT bubble
    reset_n = 1'b1;
    #7;
    reset_n = 1'b0;
    #1;
    chk_reset_values("por");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("boot_valid", int'(instr_valid), 0);
    chk("boot_addr",  int'(imem_addr), 0);
    tick();
    chk("first_valid", int'(instr_valid), 1);

    // Straight-line NOP run across the 255 -> 0 wrap
    for (int k = 0; k < 260; k++) begin
      chk("seq_pc",    int'(pc_out), k % 256);
      chk("seq_addr",  int'(imem_addr), (k + 1) % 256);
      chk("seq_pc1",   int'(pc_plus1), (k + 1) % 256);
      chk("seq_valid", int'(instr_valid), 1);
      tick();
    end

    // Next-PC vectors
    for (int i = 0; i < 11; i++) begin
      rom[vecs[i].start_pc] = {vecs[i].op, vecs[i].fn, vecs[i].imm};
      goto(8'(vecs[i].start_pc));
      set_ctl(1'b1, vecs[i].jump, vecs[i].cond, vecs[i].zero, vecs[i].jv, vecs[i].reg_addr);
      #1;
      chk($sformatf("vec%0d_pc", i),     int'(pc_out), vecs[i].start_pc);
      chk($sformatf("vec%0d_opcode", i), int'(Opcode), int'(vecs[i].op));
      chk($sformatf("vec%0d_funct", i),  int'(Funct), int'(vecs[i].fn));
      chk($sformatf("vec%0d_imm", i),    int'(Imm), int'(vecs[i].imm));
      chk($sformatf("vec%0d_addr", i),   int'(imem_addr), vecs[i].exp_next);
      tick();
      chk($sformatf("vec%0d_next", i),   int'(pc_out), vecs[i].exp_next);
    end

    // Three-cycle stall at pc=5, then resume at 6
    rom[5] = {2'b01, 3'b010, 11'h123};
    goto(8'd5);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_pc",     int'(pc_out), 5);
      chk("stall_addr",   int'(imem_addr), 5);
      chk("stall_opcode", int'(Opcode), 1);
      chk("stall_funct",  int'(Funct), 2);
      chk("stall_valid",  int'(instr_valid), 1);
      tick();
    end
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    #1;
    chk("resume_addr", int'(imem_addr), 6);
    tick();
    chk("resume_pc", int'(pc_out), 6);

    // Reset in the middle of a stall
    goto(8'd5);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    tick();
    tick();
    pulse_reset("rst_stall");
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    #1;
    chk("rst_stall_boot_valid", int'(instr_valid), 0);
    chk("rst_stall_boot_addr",  int'(imem_addr), 0);
    tick();
    chk("rst_stall_valid", int'(instr_valid), 1);
    chk("rst_stall_pc",    int'(pc_out), 0);
    chk("rst_stall_addr",  int'(imem_addr), 1);

    // HALT at pc=20, held while the control inputs try to move the PC
    rom[20] = {2'b11, 3'b111, 11'h055};
    goto(8'd20);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    #1;
    chk("halt_pre_valid",  int'(instr_valid), 1);
    chk("halt_pre_opcode", int'(Opcode), 3);
    chk("halt_pre_funct",  int'(Funct), 7);
    chk("halt_pre_addr",   int'(imem_addr), 20);
    tick();
    chk("halt_halted", int'(halted), 1);
    chk("halt_valid",  int'(instr_valid), 0);
    chk("halt_opcode", int'(Opcode), 0);
    chk("halt_imm",    int'(Imm), 0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 8'hAA);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("halt_hold_pc",     int'(pc_out), 20);
      chk("halt_hold_addr",   int'(imem_addr), 20);
      chk("halt_hold_halted", int'(halted), 1);
      chk("halt_hold_valid",  int'(instr_valid), 0);
    end
    pulse_reset("rst_halt");
    #1;
    chk("rst_halt_boot_valid", int'(instr_valid), 0);
    chk("rst_halt_boot_addr",  int'(imem_addr), 0);
    tick();
    chk("rst_halt_valid", int'(instr_valid), 1);
    chk("rst_halt_pc",    int'(pc_out), 0);

    // Randomized run against the reference model; HALT words sprinkled in
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    for (int i = 7; i < 256; i += 37) rom[i] = {2'b11, 3'b111, 11'($urandom)};
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    pulse_reset("rnd_rst");
    m_boot = 1'b1;
    m_halt = 1'b0;
    m_pc = 0;
    halt_cycles = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pw = ($urandom_range(0, 3) != 0);
      j  = 1'($urandom);
      c  = 1'($urandom);
      z  = 1'($urandom);
      jv = 2'($urandom);
      ra = 8'($urandom);
      set_ctl(pw, j, c, z, jv, ra);
      #1;
      w = rom[m_pc];
      tgt = ref_next(m_pc, w[10:0], j, c, z, jv, ra);
      if (m_boot)      e_addr = 0;
      else if (m_halt) e_addr = m_pc;
      else             e_addr = pw ? tgt : m_pc;
      chk("rnd_valid",  int'(instr_valid), (!m_boot && !m_halt) ? 1 : 0);
      chk("rnd_halted", int'(halted), m_halt ? 1 : 0);
      chk("rnd_addr",   int'(imem_addr), e_addr);
      chk("rnd_pc",     int'(pc_out), m_pc);
      chk("rnd_opcode", int'(Opcode), (!m_boot && !m_halt) ? int'(w[15:14]) : 0);
      chk("rnd_funct",  int'(Funct), (!m_boot && !m_halt) ? int'(w[13:11]) : 0);
      tick();
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_halt) begin
        if (pw) m_pc = tgt;
        else if (w[15:11] == 5'b11111) m_halt = 1'b1;
      end
      if (m_halt) begin
        halt_cycles++;
        if (halt_cycles > 3) begin
          pulse_reset("rnd_halt_rst");
          m_boot = 1'b1;
          m_halt = 1'b0;
          m_pc = 0;
          halt_cycles = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
